jt03_snd_fifo: RTL and testbench
================================

Name: jt03_snd_fifo

Overview:
- Sample-rate output buffer directly downstream of the YM2203 accumulator stage.
- Captures the signed 16-bit combined FM output once per sample period, on the accumulator's sample strobe qualified by clk_en.
- Delivers captured samples to the audio sink over a first-word-fall-through valid/ready stream running at full clk rate.
- Reports fill level, overflow and a count of dropped samples.

Parameters:
- AW, 3, address width; FIFO depth = 2**AW entries (default 8). Allowed range 1..6.
- DROPW, 8, width of the dropped-sample counter.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- clk_en  input  1  chip clock enable, same enable that drives the accumulator
- snd_in  input  16  signed combined FM sample from the accumulator output
- sample  input  1  end-of-sample strobe; one clk_en-qualified cycle per output sample
- out_ready  input  1  sink accepts head sample
- out_valid  output  1  head sample present
- out_data  output  16  signed head sample; 0 when empty
- level  output  AW+1  number of stored entries, 0..2**AW
- full  output  1  level == 2**AW
- overflow  output  1  sticky; set on first dropped sample
- drop_cnt  output  DROPW  dropped-sample count, saturating

Behaviour:
- Reset, synchronous with rst=1 at a clk edge:
  - Pointers, level, overflow and drop_cnt all clear to 0.
  - out_valid=0, out_data=0, full=0.
  - Reset overrides any push or pop in the same cycle.
  - Reset mid-stream discards all stored samples.
- Push condition: push_req = clk_en & sample & ~rst.
  - Writes snd_in into mem[wr_ptr]; wr_ptr increments modulo 2**AW.
- Pop condition: pop = out_valid & out_ready.
  - Independent of clk_en.
  - rd_ptr increments modulo 2**AW.
- Accept rule: a push is accepted if level < 2**AW, or if a pop occurs in the same cycle.
  - Pushing into a full FIFO with a simultaneous pop succeeds; level stays 2**AW and nothing is dropped.
- Drop rule: push_req while full and no pop in the same cycle.
  - Incoming sample discarded; stored data unchanged.
  - overflow <= 1.
  - drop_cnt increments, saturating at 2**DROPW-1.
- Level update per edge: +1 on accepted push without pop; -1 on pop without push; unchanged when both or neither occur.
- Pop on empty is impossible (out_valid=0). out_ready is ignored when empty.
- Latency:
  - A sample pushed at edge N appears on out_data with out_valid=1 in the cycle after edge N (one clk).
  - A push into an empty FIFO does not bypass combinationally.
- FWFT: out_data = mem[rd_ptr] when level != 0, else 16'd0.
  - out_data and out_valid depend only on registered state; no combinational path from out_ready.
- Stability: while out_valid=1 and out_ready=0, out_data holds its value.
- Data handling: no arithmetic on data; the 16-bit value is stored verbatim, sign preserved.
- overflow and drop_cnt clear only on rst.
- Pointer storage:
  - Pointers are AW bits.
  - level is a separate AW+1-bit register, or derived from AW+1-bit pointers; either way full/empty must be distinguishable at wrap.
- Memory: mem is registers or inferred RAM. Contents are not reset; only pointers are reset.

Test Plan:
- Reset: hold rst 3 cycles with sample pulses and out_ready=1 -> out_valid=0, out_data=0, level=0, overflow=0, drop_cnt=0 throughout.
- Single sample: clk_en=1, sample=1, snd_in=16'h8001 for one cycle, out_ready=0 -> next cycle out_valid=1, out_data=16'h8001, level=1. Raise out_ready -> after one edge level=0, out_data=0.
- clk_en gating: sample=1 with clk_en=0 for 5 cycles -> level stays 0. With out_ready=1 and clk_en=0, stored entries still drain one per cycle.
- Fill and drop (AW=3): push 10 samples 0x0001..0x000A with out_ready=0 -> level=8, full=1, overflow=1, drop_cnt=2. Drain reads 0x0001..0x0008 in order.
- Full with simultaneous push and pop: at level=8, push 0x1234 while out_ready=1 -> level stays 8, drop_cnt unchanged, and 0x1234 is read 8th after further drain. Also push 300 samples into a full FIFO without pops -> drop_cnt saturates at 255.
- Wrap-around and mid-stream reset: 20 alternating push/pop rounds cross pointer wrap with data in order. Assert rst at level=5 -> next cycle level=0, out_valid=0; a following push reads back correctly.

Source files
------------

// File: rtl/jt03_snd_fifo.sv
// Sample-rate output buffer behind the YM2203 accumulator: captures one signed
// sample per strobe and hands it to the audio sink over a FWFT valid/ready stream.
module jt03_snd_fifo #(
  parameter int AW    = 3,
  parameter int DROPW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic [15:0]       snd_in,
  input  logic              sample,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [15:0]       out_data,
  output logic [AW:0]       level,
  output logic              full,
  output logic              overflow,
  output logic [DROPW-1:0]  drop_cnt
);

  localparam int DEPTH = 1 << AW;

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_req;
  logic          pop;
  logic          accept;
  logic          drop;

  // level only reaches 2**AW when full, so its top bit alone marks full
  assign full      = level[AW];
  assign out_valid = |level;
  assign out_data  = out_valid ? mem[rd_ptr] : 16'd0;

  assign push_req = clk_en & sample & ~rst;
  assign pop      = out_valid & out_ready;
  assign accept   = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  // Storage is left unreset so it can map onto RAM; only the pointers matter
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= snd_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_jt03_snd_fifo.sv
// Self-checking bench for jt03_snd_fifo: a vector table, directed corner
// sequences and a randomized run, all compared against a queue-based model.
module tb_jt03_snd_fifo;

  localparam int AW    = 3;
  localparam int DROPW = 8;
  localparam int DEPTH = 1 << AW;
  localparam int DMAX  = (1 << DROPW) - 1;

  logic        clk = 1'b0;
  logic        rst, clk_en, sample, out_ready;
  logic [15:0] snd_in;
  logic        out_valid, full, overflow;
  logic [15:0] out_data;
  logic [AW:0] level;
  logic [DROPW-1:0] drop_cnt;

  int tests  = 0;
  int failed = 0;

  logic [15:0] mq[$];
  int          m_overflow;
  int          m_drop;

  jt03_snd_fifo #(.AW(AW), .DROPW(DROPW)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .snd_in(snd_in), .sample(sample),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .level(level), .full(full), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic        en;
    logic        smp;
    logic [15:0] d;
    logic        rdy;
    logic        ev;
    logic [15:0] ed;
    logic [AW:0] el;
  } vec_t;

  vec_t vecs[14];

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour: a plain queue with the accept/drop rules applied to it
  task automatic modelStep(input logic r, input logic en, input logic smp,
                           input logic [15:0] d, input logic rdy);
    bit do_pop;
    if (r) begin
      mq.delete();
      m_overflow = 0;
      m_drop     = 0;
    end else begin
      do_pop = (mq.size() != 0) && rdy;
      if (do_pop) void'(mq.pop_front());
      if (en && smp) begin
        if (mq.size() < DEPTH) mq.push_back(d);
        else begin
          m_overflow = 1;
          if (m_drop < DMAX) m_drop++;
        end
      end
    end
  endtask

  task automatic checkOutput();
    logic [15:0] head;
    head = (mq.size() != 0) ? mq[0] : 16'd0;
    checkVal("out_valid", out_valid, (mq.size() != 0));
    checkVal("out_data",  out_data,  head);
    checkVal("level",     level,     mq.size());
    checkVal("full",      full,      (mq.size() == DEPTH));
    checkVal("overflow",  overflow,  m_overflow);
    checkVal("drop_cnt",  drop_cnt,  m_drop);
  endtask

  task automatic applyStimulus(input logic r, input logic en, input logic smp,
                               input logic [15:0] d, input logic rdy);
    rst       = r;
    clk_en    = en;
    sample    = smp;
    snd_in    = d;
    out_ready = rdy;
    modelStep(r, en, smp, d, rdy);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic idleCycle(input logic rdy);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'd0, rdy);
  endtask

  task automatic pushOne(input logic [15:0] d, input logic rdy);
    applyStimulus(1'b0, 1'b1, 1'b1, d, rdy);
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b1, 1'b1, 16'hDEAD, 1'b1);
  endtask

  initial begin
    logic [15:0] drain_exp[$];
    int bias;

    rst = 1'b1; clk_en = 1'b0; sample = 1'b0; snd_in = '0; out_ready = 1'b0;
    m_overflow = 0; m_drop = 0;

    vecs[0]  = '{1'b1, 1'b1, 1'b1, 16'h1111, 1'b1, 1'b0, 16'h0000, 4'd0};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 16'h2222, 1'b1, 1'b0, 16'h0000, 4'd0};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 16'h3333, 1'b1, 1'b0, 16'h0000, 4'd0};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 16'h8001, 1'b0, 1'b1, 16'h8001, 4'd1};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 4'd0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 16'h7777, 1'b1, 1'b0, 16'h0000, 4'd0};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 16'h7777, 1'b1, 1'b0, 16'h0000, 4'd0};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 16'h7777, 1'b0, 1'b0, 16'h0000, 4'd0};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 16'h7777, 1'b0, 1'b0, 16'h0000, 4'd0};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 16'h7777, 1'b1, 1'b0, 16'h0000, 4'd0};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 16'h00AA, 1'b0, 1'b1, 16'h00AA, 4'd1};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 16'h00BB, 1'b0, 1'b1, 16'h00AA, 4'd2};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b1, 16'h00BB, 4'd1};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 4'd0};

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].r, vecs[i].en, vecs[i].smp, vecs[i].d, vecs[i].rdy);
      checkVal("vec_valid", out_valid, vecs[i].ev);
      checkVal("vec_data",  out_data,  vecs[i].ed);
      checkVal("vec_level", level,     vecs[i].el);
    end

    // Fill past capacity, then push into a full FIFO while popping
    doReset();
    for (int i = 1; i <= 10; i++) pushOne(16'(i), 1'b0);
    checkVal("fill_level", level, 8);
    checkVal("fill_full", full, 1);
    checkVal("fill_overflow", overflow, 1);
    checkVal("fill_drop", drop_cnt, 2);
    checkVal("fill_head", out_data, 16'h0001);
    pushOne(16'h1234, 1'b1);
    checkVal("fullpp_level", level, 8);
    checkVal("fullpp_drop", drop_cnt, 2);
    drain_exp = '{16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006,
                  16'h0007, 16'h0008, 16'h1234};
    foreach (drain_exp[i]) begin
      checkVal("drain_data", out_data, drain_exp[i]);
      idleCycle(1'b1);
    end
    checkVal("drain_empty", out_valid, 0);

    // Drop counter saturation
    doReset();
    for (int i = 0; i < DEPTH; i++) pushOne(16'hA000 + 16'(i), 1'b0);
    for (int i = 0; i < 300; i++) pushOne(16'h5A5A, 1'b0);
    checkVal("sat_drop", drop_cnt, 255);
    checkVal("sat_overflow", overflow, 1);
    checkVal("sat_head", out_data, 16'hA000);

    // Alternating push/pop rounds crossing pointer wrap
    doReset();
    for (int i = 0; i < 3; i++) pushOne(16'hC000 + 16'(i), 1'b0);
    for (int r = 0; r < 20; r++) begin
      pushOne(16'h4000 + 16'(r), 1'b0);
      idleCycle(1'b1);
    end
    checkVal("wrap_level", level, 3);
    checkVal("wrap_head", out_data, 16'h4011);

    // Mid-stream reset discards contents
    doReset();
    for (int i = 0; i < 5; i++) pushOne(16'hE000 + 16'(i), 1'b0);
    checkVal("mid_level", level, 5);
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h5555, 1'b1);
    checkVal("mid_rst_level", level, 0);
    checkVal("mid_rst_valid", out_valid, 0);
    pushOne(16'hBEEF, 1'b0);
    checkVal("mid_after", out_data, 16'hBEEF);

    // Randomized run with phases of slow, balanced and eager sinks
    bias = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) bias = (c / 200 % 3 == 0) ? 10 : ((c / 200 % 3 == 1) ? 90 : 50);
      applyStimulus(($urandom_range(0, 199) == 0),
                    ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 1) == 1),
                    16'($urandom),
                    ($urandom_range(0, 99) < bias));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
